sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter SRAM_ADDR_WD, default 9, SRAM word address width.
REQ-002 Parameter SRAM_DATA_WD, default 32, SRAM data width; byte-mask width is SRAM_DATA_WD/8.
REQ-003 wb_clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-005 mN_req  input  1  requester N (N=0,1) access request; held high until mN_ack.
REQ-006 mN_we  input  1  requester N: 1 = write, 0 = read.
REQ-007 mN_addr  input  SRAM_ADDR_WD  requester N word address.
REQ-008 mN_wdata  input  SRAM_DATA_WD  requester N write data.
REQ-009 mN_mask  input  SRAM_DATA_WD/8  requester N byte-write mask, 1 = byte written.
REQ-010 mN_ack  output  1  requester N one-cycle completion pulse.
REQ-011 mN_rdata  output  SRAM_DATA_WD  requester N read data, valid while mN_ack is high after a read.
REQ-012 sram_csb_a  output  1  port A (read) chip select, active-low.
REQ-013 sram_addr_a  output  SRAM_ADDR_WD  port A address.
REQ-014 sram_dout_a  input  SRAM_DATA_WD  port A read data.
REQ-015 sram_csb_b, sram_web_b  output  1 each  port B chip select and write enable, active-low.
REQ-016 sram_mask_b  output  SRAM_DATA_WD/8  port B byte mask.
REQ-017 sram_addr_b  output  SRAM_ADDR_WD  port B address.
REQ-018 sram_din_b  output  SRAM_DATA_WD  port B write data.
REQ-019 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT and ACK; only one access SHALL be in flight at any time.
REQ-021 In IDLE, mN_req, mN_we, mN_addr, mN_wdata and mN_mask SHALL be sampled; with any req high, the winner SHALL be chosen, its command latched, and the FSM SHALL go to ISSUE.
REQ-022 Arbitration SHALL be round-robin: when both req are high, the requester not granted last wins; a lone requester always wins.
REQ-023 The last-grant register SHALL update only in ACK.
REQ-024 ISSUE on a read (one cycle): sram_csb_a=0 and sram_addr_a=latched address; next state WAIT.
REQ-025 ISSUE on a write (one cycle): sram_csb_b=0, sram_web_b=0, and sram_mask_b, sram_addr_b, sram_din_b = latched values; next state ACK.
REQ-026 WAIT (one cycle): sram_dout_a SHALL be captured into the owner's rdata register at the end of the cycle; next state ACK.
REQ-027 ACK (one cycle): the owner's mN_ack=1 and the other requester's ack=0; next state IDLE.
REQ-028 Latency from req sampled in IDLE (cycle 0): write ack in cycle 2, read ack in cycle 3, with the next grant possible in cycle 4 (read) or cycle 3 (write).
REQ-029 req SHALL be ignored outside IDLE; a req still high in the cycle after its ack SHALL be treated as a new request.
REQ-030 Outside ISSUE, sram_csb_a, sram_csb_b and sram_web_b SHALL be 1; address, data and mask outputs SHALL hold their last driven values.
REQ-031 Port A and port B SHALL never be selected in the same cycle.
REQ-032 A write with mask 0 SHALL still run a full write cycle and be acked.
REQ-033 mN_rdata SHALL hold its value until the next read completes for that requester; a write SHALL NOT change it.
REQ-034 The address SHALL be used unmodified; there is no wrap-around or range check.

Reset
REQ-035 While wb_rst_i=1 at a clock edge: FSM=IDLE, last-grant=1 (m0 wins the first tie), all acks=0, busy_o=0, sram_csb_a=sram_csb_b=sram_web_b=1, and addr, din, mask and rdata=0.
REQ-036 Reset asserted mid-access SHALL abort the access: no ack issued, and SRAM selects high from the next edge.

Verification
REQ-037 m0 read, addr 0x005, sram_dout_a=0xDEADBEEF -> csb_a=0 in cycle 1 with addr_a=0x005; m0_ack and m0_rdata=0xDEADBEEF in cycle 3.
REQ-038 m1 write, addr 0x1FF, data 0x12345678, mask 0xF -> cycle 1: csb_b=0, web_b=0, addr_b=0x1FF, din_b=0x12345678, mask_b=0xF; m1_ack in cycle 2; csb_a stays 1 throughout.
REQ-039 m0 and m1 request reads together from reset -> m0 acked first, m1 acked next; repeating both requests -> order alternates m0, m1, m0, m1.
REQ-040 m0 write with mask 0x0 -> port B cycle issued with mask_b=0x0 and m0_ack in cycle 2; m0_rdata unchanged.
REQ-041 wb_rst_i pulsed during WAIT of a read -> no ack, csb_a=1 and busy_o=0 after the edge; the next request completes normally.
REQ-042 Continuous random traffic on both requesters -> csb_a and csb_b never both 0, and each ack matches a prior request from its own requester.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of the SRAM port arbiter: two independent request/ack
// channels. The requester drives through master, the arbiter through slave.
interface sram_port_arbiter_if #(
  parameter int SRAM_ADDR_WD = 9,
  parameter int SRAM_DATA_WD = 32
);
  localparam int MASK_WD = SRAM_DATA_WD / 8;

  logic                    m0_req;
  logic                    m0_we;
  logic [SRAM_ADDR_WD-1:0] m0_addr;
  logic [SRAM_DATA_WD-1:0] m0_wdata;
  logic [MASK_WD-1:0]      m0_mask;
  logic                    m0_ack;
  logic [SRAM_DATA_WD-1:0] m0_rdata;

  logic                    m1_req;
  logic                    m1_we;
  logic [SRAM_ADDR_WD-1:0] m1_addr;
  logic [SRAM_DATA_WD-1:0] m1_wdata;
  logic [MASK_WD-1:0]      m1_mask;
  logic                    m1_ack;
  logic [SRAM_DATA_WD-1:0] m1_rdata;

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_mask,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_mask,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_mask,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_mask,
    output m0_ack, m0_rdata, m1_ack, m1_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a dual-port SRAM macro
// (port A read-only, port B write-only); one access in flight at a time.
module sram_port_arbiter #(
  parameter int SRAM_ADDR_WD = 9,
  parameter int SRAM_DATA_WD = 32
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  sram_port_arbiter_if.slave        bus,
  output logic                      sram_csb_a,
  output logic [SRAM_ADDR_WD-1:0]   sram_addr_a,
  input  logic [SRAM_DATA_WD-1:0]   sram_dout_a,
  output logic                      sram_csb_b,
  output logic                      sram_web_b,
  output logic [SRAM_DATA_WD/8-1:0] sram_mask_b,
  output logic [SRAM_ADDR_WD-1:0]   sram_addr_b,
  output logic [SRAM_DATA_WD-1:0]   sram_din_b,
  output logic                      busy_o
);

  localparam int MASK_WD = SRAM_DATA_WD / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t state_reg;
  logic   last_grant_reg;
  logic   owner_reg;
  logic   we_reg;

  logic                    req   [2];
  logic                    we    [2];
  logic [SRAM_ADDR_WD-1:0] addr  [2];
  logic [SRAM_DATA_WD-1:0] wdata [2];
  logic [MASK_WD-1:0]      mask  [2];

  assign req[0]   = bus.m0_req;
  assign we[0]    = bus.m0_we;
  assign addr[0]  = bus.m0_addr;
  assign wdata[0] = bus.m0_wdata;
  assign mask[0]  = bus.m0_mask;
  assign req[1]   = bus.m1_req;
  assign we[1]    = bus.m1_we;
  assign addr[1]  = bus.m1_addr;
  assign wdata[1] = bus.m1_wdata;
  assign mask[1]  = bus.m1_mask;

  logic any_req;
  logic winner;

  // On a tie the requester that did not own the previous completed access wins.
  always_comb begin
    any_req = req[0] | req[1];
    winner  = 1'b0;
    if (req[0] && req[1]) begin
      winner = ~last_grant_reg;
    end else if (req[1]) begin
      winner = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      we_reg         <= 1'b0;
      sram_csb_a     <= 1'b1;
      sram_addr_a    <= '0;
      sram_csb_b     <= 1'b1;
      sram_web_b     <= 1'b1;
      sram_mask_b    <= '0;
      sram_addr_b    <= '0;
      sram_din_b     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            owner_reg <= winner;
            we_reg    <= we[winner];
            state_reg <= ISSUE;
            // SRAM pins are registered here so they are live during ISSUE.
            if (we[winner]) begin
              sram_csb_b  <= 1'b0;
              sram_web_b  <= 1'b0;
              sram_addr_b <= addr[winner];
              sram_din_b  <= wdata[winner];
              sram_mask_b <= mask[winner];
            end else begin
              sram_csb_a  <= 1'b0;
              sram_addr_a <= addr[winner];
            end
          end
        end
        ISSUE: begin
          sram_csb_a <= 1'b1;
          sram_csb_b <= 1'b1;
          sram_web_b <= 1'b1;
          state_reg  <= we_reg ? ACK : WAIT;
        end
        WAIT: begin
          state_reg <= ACK;
        end
        ACK: begin
          last_grant_reg <= owner_reg;
          state_reg      <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy_o = (state_reg != IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      localparam logic ID = 1'(gi);
      logic                    ack_reg;
      logic [SRAM_DATA_WD-1:0] rdata_reg;

      // Ack is registered one state early so it is high exactly during ACK.
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          ack_reg   <= 1'b0;
          rdata_reg <= '0;
        end else begin
          ack_reg <= (owner_reg == ID) &&
                     (((state_reg == ISSUE) && we_reg) || (state_reg == WAIT));
          if ((state_reg == WAIT) && (owner_reg == ID)) begin
            rdata_reg <= sram_dout_a;
          end
        end
      end
    end
  endgenerate

  assign bus.m0_ack   = g_port[0].ack_reg;
  assign bus.m0_rdata = g_port[0].rdata_reg;
  assign bus.m1_ack   = g_port[1].ack_reg;
  assign bus.m1_rdata = g_port[1].rdata_reg;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus random two-requester
// traffic, checked every cycle against a transaction-schedule model.
module tb_sram_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.SRAM_ADDR_WD(AW), .SRAM_DATA_WD(DW)) bus ();

  logic          csb_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] dout_a;
  logic          csb_b;
  logic          web_b;
  logic [MW-1:0] mask_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] din_b;
  logic          busy;

  sram_port_arbiter #(.SRAM_ADDR_WD(AW), .SRAM_DATA_WD(DW)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .bus        (bus),
    .sram_csb_a (csb_a),
    .sram_addr_a(addr_a),
    .sram_dout_a(dout_a),
    .sram_csb_b (csb_b),
    .sram_web_b (web_b),
    .sram_mask_b(mask_b),
    .sram_addr_b(addr_b),
    .sram_din_b (din_b),
    .busy_o     (busy)
  );

  // requester drive
  logic          req_d   [2];
  logic          we_d    [2];
  logic [AW-1:0] addr_d  [2];
  logic [DW-1:0] wdata_d [2];
  logic [MW-1:0] mask_d  [2];

  assign bus.m0_req   = req_d[0];
  assign bus.m0_we    = we_d[0];
  assign bus.m0_addr  = addr_d[0];
  assign bus.m0_wdata = wdata_d[0];
  assign bus.m0_mask  = mask_d[0];
  assign bus.m1_req   = req_d[1];
  assign bus.m1_we    = we_d[1];
  assign bus.m1_addr  = addr_d[1];
  assign bus.m1_wdata = wdata_d[1];
  assign bus.m1_mask  = mask_d[1];

  // SRAM macro: registered read on A, byte-masked write on B, preload port
  logic [DW-1:0] dev_mem [512];
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_wa = '0;
  logic [DW-1:0] tb_wd = '0;
  initial dout_a = '0;
  always @(posedge clk) begin
    if (tb_we) dev_mem[tb_wa] <= tb_wd;
    if (!csb_a) dout_a <= dev_mem[addr_a];
    if (!csb_b && !web_b) begin
      for (int b = 0; b < MW; b++)
        if (mask_b[b]) dev_mem[addr_b][8*b +: 8] <= din_b[8*b +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model: one scheduled transaction ----------------
  logic [DW-1:0] model_mem [512];
  bit            chk_on = 0;
  bit            rst_prev = 0;
  bit            cur_valid = 0;
  bit            cur_owner, cur_we;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata, cur_rval;
  logic [MW-1:0] cur_mask;
  int            t_issue, t_ack, t_free;
  bit            last_g = 1;
  logic [AW-1:0] e_addr_a, e_addr_b;
  logic [DW-1:0] e_din_b;
  logic [MW-1:0] e_mask_b;
  logic [DW-1:0] e_rdata [2];
  bit            issue_now, ack_now, w;

  always @(negedge clk) begin
    if (rst_prev) begin
      cur_valid = 0; last_g = 1;
      e_addr_a = '0; e_addr_b = '0; e_din_b = '0; e_mask_b = '0;
      e_rdata[0] = '0; e_rdata[1] = '0;
      chk_on = 1;
    end
    if (chk_on) begin
      issue_now = cur_valid && (cyc == t_issue);
      ack_now   = cur_valid && (cyc == t_ack);
      if (issue_now) begin
        if (cur_we) begin
          e_addr_b = cur_addr; e_din_b = cur_wdata; e_mask_b = cur_mask;
          for (int b = 0; b < MW; b++)
            if (cur_mask[b]) model_mem[cur_addr][8*b +: 8] = cur_wdata[8*b +: 8];
        end else begin
          e_addr_a = cur_addr;
          cur_rval = model_mem[cur_addr];
        end
      end
      if (ack_now) begin
        if (!cur_we) e_rdata[cur_owner] = cur_rval;
        last_g = cur_owner;
        $display("txn cycle %0d: m%0d %s addr %h data %h mask %h", cyc, cur_owner,
                 cur_we ? "write" : "read ", cur_addr, cur_we ? cur_wdata : cur_rval, cur_mask);
      end
      chk("csb_a",     csb_a, !(issue_now && !cur_we));
      chk("csb_b",     csb_b, !(issue_now && cur_we));
      chk("web_b",     web_b, !(issue_now && cur_we));
      chk("addr_a",    addr_a, e_addr_a);
      chk("addr_b",    addr_b, e_addr_b);
      chk("din_b",     din_b, e_din_b);
      chk("mask_b",    mask_b, e_mask_b);
      chk("m0_ack",    bus.m0_ack, ack_now && (cur_owner == 1'b0));
      chk("m1_ack",    bus.m1_ack, ack_now && (cur_owner == 1'b1));
      chk("m0_rdata",  bus.m0_rdata, e_rdata[0]);
      chk("m1_rdata",  bus.m1_rdata, e_rdata[1]);
      chk("busy",      busy, cur_valid && (cyc >= t_issue) && (cyc < t_free));
      chk("port_excl", csb_a | csb_b, 1'b1);
      if (!rst && !(cur_valid && cyc < t_free) && (req_d[0] || req_d[1])) begin
        w = (req_d[0] && req_d[1]) ? ~last_g : req_d[1];
        cur_valid = 1; cur_owner = w; cur_we = we_d[w];
        cur_addr = addr_d[w]; cur_wdata = wdata_d[w]; cur_mask = mask_d[w];
        t_issue = cyc + 1;
        t_ack   = cyc + (we_d[w] ? 2 : 3);
        t_free  = t_ack + 1;
      end
    end
    rst_prev = rst;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_mem(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d; model_mem[a] = d;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic reset_dut();
    tick();
    rst = 1'b1; req_d[0] = 1'b0; req_d[1] = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  logic          obs_csb_a, obs_csb_b, obs_web_b;
  logic [AW-1:0] obs_addr_a, obs_addr_b;
  logic [DW-1:0] obs_din_b, obs_rdata;
  logic [MW-1:0] obs_mask_b;
  bit            a_low;

  task automatic do_access(input int n, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [MW-1:0] m, output int lat);
    tick();
    req_d[n] = 1'b1; we_d[n] = we; addr_d[n] = a; wdata_d[n] = d; mask_d[n] = m;
    lat = 0; a_low = 0;
    while (1) begin
      @(negedge clk);
      if (lat == 1) begin
        obs_csb_a = csb_a; obs_addr_a = addr_a; obs_csb_b = csb_b; obs_web_b = web_b;
        obs_addr_b = addr_b; obs_din_b = din_b; obs_mask_b = mask_b;
      end
      if (!csb_a) a_low = 1;
      if ((n == 0) ? bus.m0_ack : bus.m1_ack) begin
        obs_rdata = (n == 0) ? bus.m0_rdata : bus.m1_rdata;
        break;
      end
      lat++;
      if (lat > 20) begin
        n_checks++; n_fail++;
        $display("FAIL ack_timeout m%0d: got no ack after %0d cycles, required ack", n, lat);
        break;
      end
    end
    tick();
    req_d[n] = 1'b0;
  endtask

  task automatic new_cmd(input int n);
    we_d[n]    = 1'($urandom_range(0, 1));
    addr_d[n]  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
    wdata_d[n] = $urandom;
    mask_d[n]  = MW'($urandom);
  endtask

  int lat;
  int ord [4];
  int n_ord, guard;
  bit seen [2];

  initial begin
    for (int n = 0; n < 2; n++) begin
      req_d[n] = 0; we_d[n] = 0; addr_d[n] = '0; wdata_d[n] = '0; mask_d[n] = '0;
    end
    rst = 1'b1;
    for (int i = 0; i < 512; i++) set_mem(AW'(i), $urandom);
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_csb_a", csb_a, 1'b1);
    chk("rst_web_b", web_b, 1'b0 ^ 1'b1);
    chk("rst_m0_rdata", bus.m0_rdata, 32'h0);
    chk("rst_addr_b", addr_b, 9'h0);

    // m0 read
    set_mem(9'h005, 32'hDEADBEEF);
    do_access(0, 1'b0, 9'h005, 32'h0, 4'h0, lat);
    chk("rd_latency", lat, 3);
    chk("rd_csb_a_c1", obs_csb_a, 1'b0);
    chk("rd_addr_a_c1", obs_addr_a, 9'h005);
    chk("rd_rdata", obs_rdata, 32'hDEADBEEF);

    // m0 write with empty mask
    do_access(0, 1'b1, 9'h0AA, 32'h11223344, 4'h0, lat);
    chk("wr0_latency", lat, 2);
    chk("wr0_csb_b_c1", obs_csb_b, 1'b0);
    chk("wr0_mask_b_c1", obs_mask_b, 4'h0);
    chk("wr0_rdata_kept", bus.m0_rdata, 32'hDEADBEEF);

    // m1 full write, then read back through m0
    do_access(1, 1'b1, 9'h1FF, 32'h12345678, 4'hF, lat);
    chk("wr1_latency", lat, 2);
    chk("wr1_web_b_c1", obs_web_b, 1'b0);
    chk("wr1_addr_b_c1", obs_addr_b, 9'h1FF);
    chk("wr1_din_b_c1", obs_din_b, 32'h12345678);
    chk("wr1_mask_b_c1", obs_mask_b, 4'hF);
    chk("wr1_csb_a_idle", a_low, 1'b0);
    do_access(0, 1'b0, 9'h1FF, 32'h0, 4'h0, lat);
    chk("readback", obs_rdata, 32'h12345678);

    // round robin from reset
    reset_dut();
    tick();
    req_d[0] = 1; we_d[0] = 0; addr_d[0] = 9'h010;
    req_d[1] = 1; we_d[1] = 0; addr_d[1] = 9'h020;
    n_ord = 0; guard = 0;
    for (int i = 0; i < 4; i++) ord[i] = 2;
    while (n_ord < 4 && guard < 60) begin
      @(negedge clk);
      if (bus.m0_ack) begin ord[n_ord] = 0; n_ord++; end
      else if (bus.m1_ack) begin ord[n_ord] = 1; n_ord++; end
      guard++;
    end
    tick();
    req_d[0] = 0; req_d[1] = 0;
    chk("rr_count", n_ord, 4);
    for (int i = 0; i < 4; i++) chk("rr_order", ord[i], i % 2);

    // reset during WAIT aborts the read
    set_mem(9'h033, 32'hCAFEF00D);
    tick();
    req_d[0] = 1; we_d[0] = 0; addr_d[0] = 9'h033;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; req_d[0] = 0;
    @(negedge clk);
    chk("abort_ack", bus.m0_ack, 1'b0);
    chk("abort_csb_a", csb_a, 1'b1);
    chk("abort_busy", busy, 1'b0);
    do_access(0, 1'b0, 9'h033, 32'h0, 4'h0, lat);
    chk("abort_next_lat", lat, 3);
    chk("abort_next_rdata", obs_rdata, 32'hCAFEF00D);

    // random traffic
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      seen[0] = bus.m0_ack; seen[1] = bus.m1_ack;
      tick();
      rst = ($urandom_range(0, 799) == 0);
      for (int n = 0; n < 2; n++) begin
        if (req_d[n]) begin
          if (seen[n]) begin
            if ($urandom_range(0, 2) == 0) req_d[n] = 0;
            else new_cmd(n);
          end
        end else if ($urandom_range(0, 3) == 0) begin
          req_d[n] = 1;
          new_cmd(n);
        end
      end
    end
    rst = 1'b0;
    guard = 0;
    while ((req_d[0] || req_d[1]) && guard < 40) begin
      @(negedge clk);
      seen[0] = bus.m0_ack; seen[1] = bus.m1_ack;
      tick();
      for (int n = 0; n < 2; n++) if (seen[n]) req_d[n] = 0;
      guard++;
    end
    chk("drain", req_d[0] | req_d[1], 1'b0);
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
